ntt_perm_sequencer: RTL

//  Sequences the 257-point merged permutation network through the fixed NTT schedule:
//  - drives perm_select and latches each permuted vector.
//  - hands the vector to the butterfly datapath and waits for its completion.

---
 rtl/ntt_perm_pkg.sv | 49 ++++
 rtl/ntt_perm_watchdog.sv | 33 +++
 rtl/ntt_perm_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_perm_pkg.sv
// rtl/ntt_perm_pkg.sv - shared types and step programs for the NTT permutation sequencer
// Purpose: permutation select encodings, sequencer state type, default
//          forward/inverse step programs and a select legality helper.
// Program entry k occupies bits [4k+3:4k] = {run_dp, sel[2:0]}; step 0 is
// in the least significant nibble.
package ntt_perm_pkg;

  typedef enum logic [2:0] {
    PERM_ROT   = 3'd0,
    PERM_GRP17 = 3'd1,
    PERM_GRP5  = 3'd2,
    PERM_NONE  = 3'd3,
    PERM_RADER = 3'd4,
    PERM_CRT   = 3'd5,
    PERM_TRANS = 3'd6
  } perm_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CAPTURE,
    S_DP_GO,
    S_DP_WAIT,
    S_FIN
  } seq_state_e;

  // Listed from step 4 (MSB) down to step 0 (LSB).
  localparam logic [19:0] NTT_FWD_PROG = {
    1'b0, PERM_ROT,
    1'b1, PERM_GRP5,
    1'b1, PERM_TRANS,
    1'b1, PERM_CRT,
    1'b0, PERM_RADER
  };

  localparam logic [19:0] NTT_INV_PROG = {
    1'b0, PERM_RADER,
    1'b1, PERM_CRT,
    1'b1, PERM_TRANS,
    1'b1, PERM_GRP5,
    1'b0, PERM_ROT
  };

  // 3 is the reserved slot and 7 has no network mapping.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel != 3'd3) && (sel != 3'd7);
  endfunction

endpackage

// File: rtl/ntt_perm_watchdog.sv
// rtl/ntt_perm_watchdog.sv - saturating cycle counter guarding the datapath wait
// Purpose: counts enabled cycles since the last clear; flags expiry at TIMEOUT-1.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_clear    synchronous clear, dominates enable
//   i_enable   count this cycle
//   o_expired  counter has reached TIMEOUT-1 (holds there)
module ntt_perm_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  assign o_expired = (r_cnt == W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ntt_perm_sequencer.sv
// rtl/ntt_perm_sequencer.sv - steps the merged permutation network through the NTT schedule
// Purpose: for each program step, drives perm_select, pulses vec_we once the
//          network has settled, and optionally launches and waits on a datapath stage.
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        begin a transform (only honoured when idle)
//   i_inverse      program select, sampled with i_start
//   i_dp_done      datapath stage finished (1-cycle pulse)
//   o_perm_select  permutation network select
//   o_vec_we       vector register capture strobe
//   o_dp_start     datapath stage launch pulse
//   o_busy         high whenever not idle
//   o_done         1-cycle pulse on successful completion
//   o_err          sticky: illegal select or datapath timeout
module ntt_perm_sequencer
  import ntt_perm_pkg::*;
#(
  parameter int                     NUM_STEPS = 5,
  parameter int                     PERM_LAT  = 2,
  parameter int                     TIMEOUT   = 1024,
  parameter logic [NUM_STEPS*4-1:0] FWD_PROG  = NTT_FWD_PROG,
  parameter logic [NUM_STEPS*4-1:0] INV_PROG  = NTT_INV_PROG
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_inverse,
  input  logic       i_dp_done,
  output logic [2:0] o_perm_select,
  output logic       o_vec_we,
  output logic       o_dp_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int SW       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int LW       = (PERM_LAT > 1) ? $clog2(PERM_LAT) : 1;
  localparam int LAT_LAST = (PERM_LAT > 1) ? PERM_LAT - 2 : 0;

  seq_state_e        r_state;
  logic [SW-1:0]     r_step;
  logic [LW-1:0]     r_lat_cnt;
  logic              r_inv;
  logic              r_err;

  seq_state_e        w_state_nx;
  logic [SW-1:0]     w_step_nx;
  logic [LW-1:0]     w_lat_nx;
  logic              w_inv_nx;
  logic              w_err_nx;
  logic              w_advance;
  logic              w_enter;
  logic              w_wd_clear;
  logic              w_wd_en;
  logic              w_wd_expired;

  logic [NUM_STEPS*4-1:0] w_prog;
  logic [NUM_STEPS*4-1:0] w_nx_prog;
  logic [3:0]             w_cur_entry;
  logic [SW-1:0]          w_nx_step;
  logic [2:0]             w_nx_sel;
  logic                   w_last_step;

  assign w_last_step = (r_step == SW'(NUM_STEPS - 1));
  assign w_prog      = r_inv ? INV_PROG : FWD_PROG;
  assign w_cur_entry = w_prog[4*r_step +: 4];

  // The step about to be entered: step 0 of the requested program when
  // starting, otherwise the successor of the current step. The last step has
  // no successor, so it wraps to 0 only to keep the index in range.
  assign w_nx_prog = (r_state == S_IDLE) ? (i_inverse ? INV_PROG : FWD_PROG) : w_prog;
  assign w_nx_step = ((r_state == S_IDLE) || w_last_step) ? '0 : r_step + 1'b1;
  assign w_nx_sel  = w_nx_prog[4*w_nx_step +: 3];

  assign o_busy = (r_state != S_IDLE);
  assign o_err  = r_err;

  ntt_perm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_lat_cnt <= '0;
      r_inv     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_step    <= w_step_nx;
      r_lat_cnt <= w_lat_nx;
      r_inv     <= w_inv_nx;
      r_err     <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_step_nx     = r_step;
    w_lat_nx      = r_lat_cnt;
    w_inv_nx      = r_inv;
    w_err_nx      = r_err;
    w_advance     = 1'b0;
    w_enter       = 1'b0;
    w_wd_clear    = 1'b1;
    w_wd_en       = 1'b0;
    o_perm_select = 3'd0;
    o_vec_we      = 1'b0;
    o_dp_start    = 1'b0;
    o_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_inv_nx = i_inverse;
          w_err_nx = 1'b0;
          w_enter  = 1'b1;
        end
      end
      S_SETUP: begin
        o_perm_select = w_cur_entry[2:0];
        if (r_lat_cnt == LW'(LAT_LAST)) begin
          w_state_nx = S_CAPTURE;
        end else begin
          w_lat_nx = r_lat_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        o_perm_select = w_cur_entry[2:0];
        o_vec_we      = 1'b1;
        if (w_cur_entry[3]) begin
          w_state_nx = S_DP_GO;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_DP_GO: begin
        // Watchdog starts counting on the launch cycle, so expiry lands
        // exactly TIMEOUT cycles after dp_start.
        o_dp_start = 1'b1;
        w_wd_clear = 1'b0;
        w_wd_en    = 1'b1;
        w_state_nx = S_DP_WAIT;
      end
      S_DP_WAIT: begin
        w_wd_clear = 1'b0;
        w_wd_en    = 1'b1;
        // Completion wins over a coincident expiry.
        if (i_dp_done) begin
          w_advance = 1'b1;
        end else if (w_wd_expired) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_FIN: begin
        o_done     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_advance) begin
      if (w_last_step) begin
        w_state_nx = S_FIN;
      end else begin
        w_enter = 1'b1;
      end
    end

    // Legality is judged as a step is entered, so an illegal step never
    // drives the network or strobes vec_we, whatever PERM_LAT is.
    if (w_enter) begin
      w_step_nx = w_nx_step;
      w_lat_nx  = '0;
      if (!sel_is_legal(w_nx_sel)) begin
        w_err_nx   = 1'b1;
        w_state_nx = S_IDLE;
      end else begin
        w_state_nx = (PERM_LAT > 1) ? S_SETUP : S_CAPTURE;
      end
    end
  end

endmodule
